key_input_tracker: RTL and testbench
====================================

Name: key_input_tracker

Overview:
- Sits directly upstream of the paddle stage, between the USB keyboard report path and the paddle block.
- Decodes 4-slot HID keycode reports into per-key held flags: W, S, Up, Down, Space.
- Publishes the W/S/Up/Down flags to the paddle block, updated only on frame_clk edges.
- Emits a one-cycle serve pulse on a Space press and clears all keys when the report stream goes stale.

Parameters:
- TIMEOUT_CYCLES, 5000000, Clk cycles without an accepted report before all keys are forced released (100 ms at 50 MHz).
- W_CODE, 8'h1A, HID usage for W.
- S_CODE, 8'h16, HID usage for S.
- UP_CODE, 8'h52, HID usage for Up arrow.
- DOWN_CODE, 8'h51, HID usage for Down arrow.
- SERVE_CODE, 8'h2C, HID usage for Space.

Ports:
- Clk  input  1  system clock (50 MHz).
- Reset_n  input  1  reset; asynchronous, active-low.
- keycode  input  32  four HID keycode slots; [7:0] is slot 0 … [31:24] is slot 3.
- keycode_valid  input  1  one-Clk strobe: keycode holds a new report.
- frame_clk  input  1  vertical-sync frame tick, asynchronous to Clk.
- w_key  output  1  frame-aligned W held.
- s_key  output  1  frame-aligned S held.
- up_key  output  1  frame-aligned Up held.
- down_key  output  1  frame-aligned Down held.
- serve_pulse  output  1  one-Clk pulse on a Space press.
- stale  output  1  no accepted report for TIMEOUT_CYCLES.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - All raw flags, outputs, sync flops and the timeout counter clear to 0.
  - stale resets to 1: no report has been seen yet.
- Report accept: on a Clk edge with keycode_valid=1.
  - If any slot equals 8'h01 (rollover error), the report is discarded: flags and counter unchanged.
  - Otherwise the report is accepted:
    - each raw flag <= OR over the 4 slots of (slot == CODE);
    - slots of 8'h00 match nothing;
    - a duplicate code in several slots is harmless.
  - An accepted report clears the timeout counter and clears stale on the same edge.
- Timeout:
  - The counter increments each Clk with no accepted report, saturating at TIMEOUT_CYCLES.
  - On the edge it reaches TIMEOUT_CYCLES, all raw flags clear and stale=1.
  - An accepted report on that same edge wins: flags load, counter=0, stale=0.
- Frame alignment:
  - frame_clk passes through a 2-flop synchronizer plus 1 history flop.
  - A rising edge is detected when sync=1 and history=0.
  - On the detect cycle, w/s/up/down outputs load the current raw flags.
  - Latency: 3 Clk from the frame_clk rising edge to the output change.
  - Outputs hold constant between frame edges. A press and release inside one frame is never seen by the paddle stage.
- Serve:
  - Independent of frame alignment.
  - serve_pulse=1 for exactly one Clk after raw_serve goes 0→1.
  - Holding Space produces no repeat pulse.
  - A release (report without Space, or timeout) followed by a re-press gives a new pulse.
- Opposing keys: both W and S (or Up and Down) may be asserted together; resolution belongs downstream unless the optional feature is compiled in.
- Reset asserted mid-frame or mid-report: everything returns to reset values immediately; no pulse is emitted on release of reset.

Optional Feature:
- Macro: KEY_SOCD_EN.
- Defined: per player, last-pressed-wins.
  - A 1-bit "last" register per pair records which key of the pair most recently rose in the raw flags; it resets to 0 (W / Up).
  - When both keys of a pair are raw-held, only the key named by "last" is forwarded at the frame edge.
  - If both rise in the same report, the down-direction key (S / Down) wins.
- Undefined: both flags are forwarded unmodified; no extra registers.

Test Plan:
- Reset_n low then high → all key outputs 0, serve_pulse 0, stale 1. Report keycode=32'h0000001A + frame_clk edge → w_key=1 exactly 3 Clk after the edge, stale=0.
- Report 32'h00510016 → s_key=1 and down_key=1 at the next frame edge. Report 32'h0 → both 0 at the following edge, not before.
- Report 32'h0000002C held over 3 reports → serve_pulse high one Clk only. Then 32'h0, then 32'h2C → a second single pulse.
- Held W, then no reports for TIMEOUT_CYCLES (set to 16) → stale=1 and raw cleared at cycle 16; w_key=0 after the next frame edge. Report arriving on cycle 16 → w_key kept, stale=0.
- Held Up, then report 32'h01010101 → discarded; up_key stays 1 and the counter is not cleared.
- Held W, then report 32'h0000161A:
  - with KEY_SOCD_EN: w_key=0, s_key=1;
  - without it: both 1.

Source files
------------

// File: rtl/key_input_tracker.sv
// key_input_tracker: decodes HID keycode reports into held-key flags, publishes
// W/S/Up/Down on frame_clk rising edges, pulses serve_pulse on a Space press,
// and releases every key when no report is accepted for TIMEOUT_CYCLES.
// Ports: Clk, Reset_n (async active-low), keycode[31:0] (4 slots, slot 0 in
// [7:0]), keycode_valid (report strobe), frame_clk (async frame tick);
// outputs w_key/s_key/up_key/down_key (frame-aligned), serve_pulse, stale.
// Optional macro KEY_SOCD_EN: last-pressed-wins resolution of opposing keys.
module key_input_tracker #(
  parameter int         TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0] W_CODE         = 8'h1A,
  parameter logic [7:0] S_CODE         = 8'h16,
  parameter logic [7:0] UP_CODE        = 8'h52,
  parameter logic [7:0] DOWN_CODE      = 8'h51,
  parameter logic [7:0] SERVE_CODE     = 8'h2C
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] keycode,
  input  logic        keycode_valid,
  input  logic        frame_clk,
  output logic        w_key,
  output logic        s_key,
  output logic        up_key,
  output logic        down_key,
  output logic        serve_pulse,
  output logic        stale
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // raw flag order: {serve, down, up, s, w}
  logic [4:0]    r_raw;
  logic [CW-1:0] r_cnt;
  logic          r_fs1, r_fs2, r_fh;
  logic [4:0]    w_dec, w_raw_nx;
  logic [3:0]    w_fwd;
  logic          w_roll, w_acc, w_to, w_rise;
  always_comb begin
    w_dec  = '0;
    w_roll = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_roll = w_roll | (keycode[8*i +: 8] == 8'h01);
      w_dec  = w_dec | ({5{keycode[8*i +: 8] != 8'h00}} &
               {keycode[8*i +: 8] == SERVE_CODE, keycode[8*i +: 8] == DOWN_CODE,
                keycode[8*i +: 8] == UP_CODE, keycode[8*i +: 8] == S_CODE,
                keycode[8*i +: 8] == W_CODE});
    end
  end
  assign w_acc    = keycode_valid & ~w_roll;
  // an accepted report on the saturating edge takes precedence over the timeout
  assign w_to     = ~w_acc & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_raw_nx = w_acc ? w_dec : w_to ? 5'b0 : r_raw;
  assign w_rise   = r_fs2 & ~r_fh;
`ifdef KEY_SOCD_EN
  // r_last_*: 0 = W/Up pressed most recently, 1 = S/Down
  logic r_last_ws, r_last_ud;
  assign w_fwd = {r_raw[3] & ~(r_raw[2] & ~r_last_ud), r_raw[2] & ~(r_raw[3] & r_last_ud),
                  r_raw[1] & ~(r_raw[0] & ~r_last_ws), r_raw[0] & ~(r_raw[1] & r_last_ws)};
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_last_ws <= 1'b0;
      r_last_ud <= 1'b0;
    end else begin
      // a simultaneous rise of both keys resolves toward S/Down
      r_last_ws <= (w_raw_nx[1] & ~r_raw[1]) ? 1'b1 : (w_raw_nx[0] & ~r_raw[0]) ? 1'b0 : r_last_ws;
      r_last_ud <= (w_raw_nx[3] & ~r_raw[3]) ? 1'b1 : (w_raw_nx[2] & ~r_raw[2]) ? 1'b0 : r_last_ud;
    end
  end
`else
  assign w_fwd = r_raw[3:0];
`endif
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_raw       <= '0;
      r_cnt       <= '0;
      r_fs1       <= 1'b0;
      r_fs2       <= 1'b0;
      r_fh        <= 1'b0;
      w_key       <= 1'b0;
      s_key       <= 1'b0;
      up_key      <= 1'b0;
      down_key    <= 1'b0;
      serve_pulse <= 1'b0;
      stale       <= 1'b1;
    end else begin
      r_raw       <= w_raw_nx;
      r_cnt       <= w_acc ? '0 : (r_cnt == CW'(TIMEOUT_CYCLES)) ? r_cnt : r_cnt + 1'b1;
      stale       <= w_acc ? 1'b0 : w_to ? 1'b1 : stale;
      serve_pulse <= w_raw_nx[4] & ~r_raw[4];
      r_fs1       <= frame_clk;
      r_fs2       <= r_fs1;
      r_fh        <= r_fs2;
      if (w_rise) {down_key, up_key, s_key, w_key} <= w_fwd;
    end
  end
endmodule

// File: tb/tb_key_input_tracker.sv
// tb_key_input_tracker: directed stimulus with a cycle-level behavioural model
module tb_key_input_tracker;
  localparam int T = 16;
  logic        Clk = 1'b0, Reset_n = 1'b0, keycode_valid = 1'b0, frame_clk = 1'b0;
  logic [31:0] keycode = '0;
  logic        w_key, s_key, up_key, down_key, serve_pulse, stale;
  key_input_tracker #(.TIMEOUT_CYCLES(T)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .keycode_valid(keycode_valid),
    .frame_clk(frame_clk), .w_key(w_key), .s_key(s_key), .up_key(up_key),
    .down_key(down_key), .serve_pulse(serve_pulse), .stale(stale)
  );
  always #5 Clk = ~Clk;
  int passed = 0, total = 0, pcnt = 0, cyc = 0, due = -1, m_idle = 0;
  logic [4:0] m_raw = '0;
  logic [3:0] m_out = '0;
  logic       m_stale = 1'b1, m_pulse = 1'b0, m_lws = 1'b0, m_lud = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic model_reset();
    m_raw = '0; m_out = '0; m_idle = 0; m_stale = 1'b1; m_pulse = 1'b0;
    m_lws = 1'b0; m_lud = 1'b0; due = -1;
  endtask
  task automatic model_step(input logic v, input logic [31:0] kc);
    logic [4:0] old, dec;
    logic [7:0] b;
    logic [3:0] o;
    logic       roll;
    old = m_raw; dec = '0; roll = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = kc[8*i +: 8];
      if (b == 8'h01) roll = 1'b1;
      if (b == 8'h1A) dec[0] = 1'b1;
      if (b == 8'h16) dec[1] = 1'b1;
      if (b == 8'h52) dec[2] = 1'b1;
      if (b == 8'h51) dec[3] = 1'b1;
      if (b == 8'h2C) dec[4] = 1'b1;
    end
    if (v && !roll) begin
      m_raw = dec; m_idle = 0; m_stale = 1'b0;
    end else if (m_idle < T) begin
      m_idle++;
      if (m_idle == T) begin m_raw = '0; m_stale = 1'b1; end
    end
    m_pulse = m_raw[4] & ~old[4];
    if (cyc == due) begin
      o = old[3:0];
`ifdef KEY_SOCD_EN
      if (old[0] && old[1]) o[1:0] = m_lws ? 2'b10 : 2'b01;
      if (old[2] && old[3]) o[3:2] = m_lud ? 2'b10 : 2'b01;
`endif
      m_out = o;
    end
`ifdef KEY_SOCD_EN
    if (m_raw[1] && !old[1]) m_lws = 1'b1;
    else if (m_raw[0] && !old[0]) m_lws = 1'b0;
    if (m_raw[3] && !old[3]) m_lud = 1'b1;
    else if (m_raw[2] && !old[2]) m_lud = 1'b0;
`endif
  endtask
  initial forever begin
    @(posedge Clk);
    cyc++;
    if (!Reset_n) model_reset();
    else model_step(keycode_valid, keycode);
    #2;
    if (Reset_n) begin
      chk("w_key", w_key, m_out[0]);
      chk("s_key", s_key, m_out[1]);
      chk("up_key", up_key, m_out[2]);
      chk("down_key", down_key, m_out[3]);
      chk("serve_pulse", serve_pulse, m_pulse);
      chk("stale", stale, m_stale);
      if (serve_pulse) pcnt++;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic send(input logic [31:0] kc);
    keycode = kc; keycode_valid = 1'b1;
    tick(1);
    keycode_valid = 1'b0;
  endtask
  task automatic frame();
    frame_clk = 1'b1; due = cyc + 3;
    tick(4);
    frame_clk = 1'b0;
    tick(4);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    tick(3);
    chk("rst_w", w_key, 0); chk("rst_s", s_key, 0); chk("rst_up", up_key, 0);
    chk("rst_down", down_key, 0); chk("rst_serve", serve_pulse, 0); chk("rst_stale", stale, 1);
    Reset_n = 1'b1;
    tick(2);
    chk("stale_idle", stale, 1);
    send(32'h0000001A);
    chk("stale_clr", stale, 0);
    frame_clk = 1'b1; due = cyc + 3;
    tick(2); chk("w_lat2", w_key, 0);
    tick(1); chk("w_lat3", w_key, 1);
    tick(1); frame_clk = 1'b0; tick(4);
    send(32'h00510016);
    frame();
    chk("s_on", s_key, 1); chk("down_on", down_key, 1); chk("w_off", w_key, 0);
    send(32'h0);
    tick(3);
    chk("s_hold", s_key, 1); chk("down_hold", down_key, 1);
    frame();
    chk("s_rel", s_key, 0); chk("down_rel", down_key, 0);
    pcnt = 0;
    send(32'h2C); send(32'h2C); send(32'h2C);
    tick(2);
    chk("serve_once", pcnt, 1);
    send(32'h0); send(32'h2C);
    tick(2);
    chk("serve_again", pcnt, 2);
    send(32'h1A);
    frame();
    chk("to_w", w_key, 1);
    tick(7); chk("to_15", stale, 0);
    tick(1); chk("to_16", stale, 1);
    frame();
    chk("to_w_clr", w_key, 0);
    send(32'h1A);
    tick(15);
    send(32'h1A);
    chk("to_race_stale", stale, 0);
    frame();
    chk("to_race_w", w_key, 1);
    send(32'h52);
    frame();
    chk("up_on", up_key, 1);
    send(32'h01010101);
    frame();
    chk("roll_up", up_key, 1);
    chk("roll_no_clr", stale, 1);
    send(32'h1A); send(32'h161A);
    frame();
`ifdef KEY_SOCD_EN
    chk("socd_w", w_key, 0); chk("socd_s", s_key, 1);
`else
    chk("socd_w", w_key, 1); chk("socd_s", s_key, 1);
`endif
    send(32'h2C);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_serve", serve_pulse, 0); chk("mid_rst_stale", stale, 1);
    chk("mid_rst_w", w_key, 0); chk("mid_rst_s", s_key, 0);
    tick(2);
    Reset_n = 1'b1;
    pcnt = 0;
    tick(4);
    chk("rst_no_pulse", pcnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
